// File: rtl/deserializer_pingpong_pkg.sv
// Shared types and helpers for the ping-pong deserializer.
// eff_len maps the runtime length request onto a legal frame length.
package deserializer_pingpong_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // A length of 0 or one larger than the bank means "use the whole bank".
  function automatic int eff_len(input int cfg_len, input int n_samples);
    return (cfg_len == 0 || cfg_len > n_samples) ? n_samples : cfg_len;
  endfunction

endpackage

// File: rtl/deserializer_pingpong_if.sv
// Word-stream input and frame output of the deserializer.
// The slave modport is the deserializer's view; master is the environment's view.
interface deserializer_pingpong_if #(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
);
  localparam int LW = $clog2(N_SAMPLES + 1);

  logic [LW-1:0]                       cfg_len;
  logic                                recv_val;
  logic                                recv_rdy;
  logic [BIT_WIDTH-1:0]                recv_msg;
  logic                                recv_last;
  logic                                send_val;
  logic                                send_rdy;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg;
  logic [LW-1:0]                       send_len;
  logic [N_SAMPLES-1:0]                send_mask;

  modport slave (
    input  cfg_len, recv_val, recv_msg, recv_last, send_rdy,
    output recv_rdy, send_val, send_msg, send_len, send_mask
  );

  modport master (
    output cfg_len, recv_val, recv_msg, recv_last, send_rdy,
    input  recv_rdy, send_val, send_msg, send_len, send_mask
  );

endinterface

// File: rtl/deserializer_pingpong_bank.sv
// One frame buffer: collects words into slots 0.. until the frame completes, then holds it.
// state | meaning: BANK_EMPTY | filling (count words stored) ; BANK_FULL | frame held until drain
module deserializer_pingpong_bank
  import deserializer_pingpong_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32,
  parameter int LW        = $clog2(N_SAMPLES + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en_i,
  input  logic                                last_i,
  input  logic [LW-1:0]                       cfg_len_i,
  input  logic [BIT_WIDTH-1:0]                msg_i,
  input  logic                                drain_i,
  output logic                                full_o,
  output logic                                done_o,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] data_o,
  output logic [LW-1:0]                       len_o
);

  bank_state_e                         state_q, state_d;
  logic [LW-1:0]                       count_q, count_d;
  logic [LW-1:0]                       len_q, len_d;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] data_q, data_d;
  logic [LW-1:0]                       tgt_len;
  logic [LW-1:0]                       count_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BANK_EMPTY;
      count_q <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    data_d    = data_q;
    // cfg_len only matters on the first word; afterwards the latched length rules.
    tgt_len   = (count_q == '0) ? LW'(eff_len(int'(cfg_len_i), N_SAMPLES)) : len_q;
    count_inc = count_q + LW'(1);
    done_o    = wr_en_i && (last_i || count_inc == tgt_len);
    if (wr_en_i) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        if (count_q == LW'(i)) data_d[i] = msg_i;
      end
      count_d = count_inc;
      len_d   = tgt_len;
      if (done_o) begin
        state_d = BANK_FULL;
        len_d   = count_inc;
        count_d = '0;
      end
    end
    if (drain_i) state_d = BANK_EMPTY;
  end

  assign full_o = (state_q == BANK_FULL);
  assign data_o = data_q;
  assign len_o  = len_q;

endmodule

// File: rtl/deserializer_pingpong.sv
// Double-buffered deserializer: one bank fills while the other is presented on send_msg.
// Top holds the fill/present selectors, the handshakes and the output masking.
module deserializer_pingpong
  import deserializer_pingpong_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  deserializer_pingpong_if.slave  bus
);

  localparam int LW = $clog2(N_SAMPLES + 1);

  logic                                wr_sel_q, wr_sel_d;
  logic                                rd_sel_q, rd_sel_d;
  logic                                accept, pop;
  logic                                wr_en [2];
  logic                                drain [2];
  logic                                full  [2];
  logic                                done  [2];
  logic [LW-1:0]                       len   [2];
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] data  [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    deserializer_pingpong_bank #(
      .N_SAMPLES (N_SAMPLES),
      .BIT_WIDTH (BIT_WIDTH),
      .LW        (LW)
    ) u_bank (
      .clk       (clk),
      .rst_n     (reset),
      .wr_en_i   (wr_en[b]),
      .last_i    (bus.recv_last),
      .cfg_len_i (bus.cfg_len),
      .msg_i     (bus.recv_msg),
      .drain_i   (drain[b]),
      .full_o    (full[b]),
      .done_o    (done[b]),
      .data_o    (data[b]),
      .len_o     (len[b])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  always_comb begin
    bus.recv_rdy = reset && !full[wr_sel_q];
    bus.send_val = full[rd_sel_q];
    accept       = bus.recv_val && bus.recv_rdy;
    pop          = bus.send_val && bus.send_rdy;
    wr_en[0]     = accept && !wr_sel_q;
    wr_en[1]     = accept &&  wr_sel_q;
    drain[0]     = pop && !rd_sel_q;
    drain[1]     = pop &&  rd_sel_q;
    wr_sel_d     = wr_sel_q ^ (done[0] || done[1]);
    rd_sel_d     = rd_sel_q ^ pop;
  end

  // Slots beyond the frame length are forced to zero so stale words never leak out.
  always_comb begin
    bus.send_len  = len[rd_sel_q];
    bus.send_mask = '0;
    bus.send_msg  = '0;
    for (int i = 0; i < N_SAMPLES; i++) begin
      bus.send_mask[i] = (LW'(i) < len[rd_sel_q]);
      if (bus.send_mask[i]) bus.send_msg[i] = data[rd_sel_q][i];
    end
  end

endmodule

// File: tb/tb_deserializer_pingpong.sv
// Directed bench for the ping-pong deserializer with N_SAMPLES=4, BIT_WIDTH=8.
// A vector table covers length/last/mask cases; hand sequences cover buffering, streaming and reset.
module tb_deserializer_pingpong;

  localparam int N  = 4;
  localparam int BW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  deserializer_pingpong_if #(.N_SAMPLES(N), .BIT_WIDTH(BW)) bus ();

  deserializer_pingpong #(.N_SAMPLES(N), .BIT_WIDTH(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [2:0]  cfg;
    int          n;
    int          last_at;
    logic [2:0]  len;
    logic [3:0]  mask;
    logic [31:0] msg;
  } vec_t;

  vec_t        vecs [7];
  int          checks   = 0;
  int          failures = 0;
  int          w, n, drops;
  logic        rdy;
  logic [31:0] frames [$];
  logic [31:0] act, exp;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic put(input logic [7:0] m, input logic l, input logic [2:0] cl);
    int t = 0;
    bus.recv_val  = 1'b1;
    bus.recv_msg  = m;
    bus.recv_last = l;
    bus.cfg_len   = cl;
    while (bus.recv_rdy !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 20) begin
      checks++;
      failures++;
      $display("FAIL put_timeout actual=recv_rdy_low expected=recv_rdy_high");
    end
    @(posedge clk); #1;
    bus.recv_val = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_recv_rdy"}, 32'(bus.recv_rdy), 32'd0);
    chk({tag, "_send_val"}, 32'(bus.send_val), 32'd0);
    chk({tag, "_send_msg"}, 32'(bus.send_msg), 32'd0);
    chk({tag, "_send_len"}, 32'(bus.send_len), 32'd0);
    chk({tag, "_send_mask"}, 32'(bus.send_mask), 32'd0);
  endtask

  initial begin
    bus.recv_val  = 1'b0;
    bus.recv_msg  = '0;
    bus.recv_last = 1'b0;
    bus.cfg_len   = '0;
    bus.send_rdy  = 1'b0;

    //           cfg   n  last  len   mask   msg (slot3..slot0)
    vecs[0] = '{3'd4, 4, -1, 3'd4, 4'hF, 32'h13121110};
    vecs[1] = '{3'd0, 4, -1, 3'd4, 4'hF, 32'h23222120};
    vecs[2] = '{3'd7, 4, -1, 3'd4, 4'hF, 32'h33323130};
    vecs[3] = '{3'd3, 3, -1, 3'd3, 4'h7, 32'h00424140};
    vecs[4] = '{3'd4, 2,  1, 3'd2, 4'h3, 32'h00005150};
    vecs[5] = '{3'd1, 1, -1, 3'd1, 4'h1, 32'h00000060};
    vecs[6] = '{3'd4, 1,  0, 3'd1, 4'h1, 32'h00000070};

    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("in_reset");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_reset", 32'(bus.recv_rdy), 32'd1);

    // Table: fill with send_rdy low, inspect the held frame, then drain it.
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        put(8'((v + 1) * 16 + k), k == vecs[v].last_at, (k == 0) ? vecs[v].cfg : 3'd2);
        if (k < vecs[v].n - 1)
          chk($sformatf("v%0d_pending_w%0d", v, k), 32'(bus.send_val), 32'd0);
      end
      chk($sformatf("v%0d_send_val", v), 32'(bus.send_val), 32'd1);
      chk($sformatf("v%0d_send_len", v), 32'(bus.send_len), 32'(vecs[v].len));
      chk($sformatf("v%0d_send_mask", v), 32'(bus.send_mask), 32'(vecs[v].mask));
      chk($sformatf("v%0d_send_msg", v), 32'(bus.send_msg), vecs[v].msg);
      chk($sformatf("v%0d_recv_rdy", v), 32'(bus.recv_rdy), 32'd1);
      bus.send_rdy = 1'b1;
      @(posedge clk); #1;
      bus.send_rdy = 1'b0;
      chk($sformatf("v%0d_drained", v), 32'(bus.send_val), 32'd0);
    end

    // Back-to-back frame with the sink ready: visible the cycle after word 4, gone after.
    bus.send_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) put(8'(k), 1'b0, 3'd4);
    chk("t1_send_val", 32'(bus.send_val), 32'd1);
    chk("t1_send_msg", 32'(bus.send_msg), 32'h04030201);
    chk("t1_send_len", 32'(bus.send_len), 32'd4);
    chk("t1_send_mask", 32'(bus.send_mask), 32'hF);
    @(posedge clk); #1;
    chk("t1_consumed", 32'(bus.send_val), 32'd0);
    bus.send_rdy = 1'b0;

    // Both banks fill while the sink stalls; backpressure then release in order.
    w = 1;
    n = 0;
    bus.recv_val  = 1'b1;
    bus.recv_last = 1'b0;
    bus.cfg_len   = 3'd4;
    while (w <= 8 && n < 40) begin
      bus.recv_msg = 8'(w);
      rdy = bus.recv_rdy;
      @(posedge clk); #1;
      n++;
      if (rdy) w++;
    end
    bus.recv_msg = 8'd9;
    chk("t2_accepted_8", 32'(w), 32'd9);
    chk("t2_rdy_low", 32'(bus.recv_rdy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t2_rdy_still_low", 32'(bus.recv_rdy), 32'd0);
    chk("t2_frame1_held", 32'(bus.send_msg), 32'h04030201);
    bus.send_rdy = 1'b1;
    @(posedge clk); #1;
    bus.send_rdy = 1'b0;
    chk("t2_rdy_after_drain", 32'(bus.recv_rdy), 32'd1);
    chk("t2_frame2_val", 32'(bus.send_val), 32'd1);
    chk("t2_frame2_msg", 32'(bus.send_msg), 32'h08070605);
    @(posedge clk); #1;
    bus.recv_val = 1'b0;
    for (int k = 10; k <= 12; k++) put(8'(k), 1'b0, 3'd4);
    bus.send_rdy = 1'b1;
    @(posedge clk); #1;
    bus.send_rdy = 1'b0;
    chk("t2_frame3_msg", 32'(bus.send_msg), 32'h0C0B0A09);
    bus.send_rdy = 1'b1;
    @(posedge clk); #1;
    bus.send_rdy = 1'b0;
    chk("t2_all_drained", 32'(bus.send_val), 32'd0);

    // Sustained stream of 20 words with the sink always ready.
    bus.send_rdy  = 1'b1;
    bus.recv_val  = 1'b1;
    bus.recv_last = 1'b0;
    bus.cfg_len   = 3'd4;
    w = 1;
    n = 0;
    drops = 0;
    while (w <= 20 && n < 60) begin
      bus.recv_msg = 8'(w);
      if (bus.send_val) frames.push_back(32'(bus.send_msg));
      if (!bus.recv_rdy) drops++;
      rdy = bus.recv_rdy;
      @(posedge clk); #1;
      n++;
      if (rdy) w++;
    end
    bus.recv_val = 1'b0;
    repeat (3) begin
      if (bus.send_val) frames.push_back(32'(bus.send_msg));
      @(posedge clk); #1;
    end
    bus.send_rdy = 1'b0;
    chk("t5_rdy_drops", 32'(drops), 32'd0);
    chk("t5_cycles", 32'(n), 32'd20);
    chk("t5_frames", 32'(frames.size()), 32'd5);
    for (int f = 0; f < 5; f++) begin
      act = (f < frames.size()) ? frames[f] : 32'hDEADBEEF;
      exp = {8'(4 * f + 4), 8'(4 * f + 3), 8'(4 * f + 2), 8'(4 * f + 1)};
      chk($sformatf("t5_frame%0d", f), act, exp);
    end

    // Asynchronous reset with one frame pending and a partial frame in progress.
    for (int k = 0; k < 4; k++) put(8'(8'hB0 + k), 1'b0, 3'd4);
    put(8'hC0, 1'b0, 3'd4);
    put(8'hC1, 1'b0, 3'd4);
    chk("t6_pending", 32'(bus.send_val), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_zero_outputs("t6_async");
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_val_after", 32'(bus.send_val), 32'd0);
    chk("t6_rdy_after", 32'(bus.recv_rdy), 32'd1);
    for (int k = 0; k < 4; k++) put(8'(8'hA0 + k), 1'b0, 3'd4);
    chk("t6_clean_val", 32'(bus.send_val), 32'd1);
    chk("t6_clean_msg", 32'(bus.send_msg), 32'hA3A2A1A0);
    chk("t6_clean_len", 32'(bus.send_len), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
